// File: rtl/mem_responder_if.sv
// mem_responder_if: load/store handshake between the controller and the memory responder
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [17:0] rdata;
  logic        ready;
  modport master(output req, we, addr, wdata, input rdata, ready);
  modport slave(input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: serves single-word loads/stores from RAM or MMIO; define MMIO_TIMER_EN to map a cycle counter at IO_BASE+1
module mem_responder #(
  parameter int          RAM_WORDS = 1024,
  parameter logic [15:0] IO_BASE   = 16'hFF00
) (
  input  logic           CLK,
  input  logic           CLR,
  mem_responder_if.slave bus,
  input  logic [15:0]    io_in,
  output logic [15:0]    io_out,
  output logic           err
);
  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, RD, RESP} state_t;
  state_t      state_q;
  logic [15:0] addr_q;
  logic [15:0] ram_q;
  logic [15:0] cnt_q;
  logic [15:0] io_out_q;
  logic [17:0] rdata_q;
  logic        ready_q;
  logic        err_q;
  logic [15:0] mem [RAM_WORDS];
  logic [15:0] dec_addr;
  logic        ram_hit;
  logic        io_hit;
  logic        tm_hit;
  logic        accept;
  assign accept   = state_q == IDLE && bus.req;
  assign dec_addr = state_q == IDLE ? bus.addr : addr_q;
  assign ram_hit  = {1'b0, dec_addr} < 17'(RAM_WORDS);
  assign io_hit   = dec_addr == IO_BASE;
`ifdef MMIO_TIMER_EN
  assign tm_hit = dec_addr == IO_BASE + 16'd1;
  // free-running cycle counter, wraps at 16 bits
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) cnt_q <= '0;
    else cnt_q <= cnt_q + 16'd1;
  end
`else
  assign tm_hit = 1'b0;
  assign cnt_q  = '0;
`endif
  // RAM port: writes commit and reads are issued on the accept edge; contents survive reset
  always_ff @(posedge CLK) begin
    if (accept && ram_hit) begin
      if (bus.we) mem[bus.addr[AW-1:0]] <= bus.wdata;
      else ram_q <= mem[bus.addr[AW-1:0]];
    end
  end
  // transaction FSM: samples the request only in IDLE, captures read data in RD, pulses ready in RESP
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      io_out_q <= '0;
      err_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.req) begin
          addr_q  <= bus.addr;
          state_q <= bus.we ? RESP : RD;
          ready_q <= bus.we;
          if (bus.we && io_hit) io_out_q <= bus.wdata;
          if (!(ram_hit || io_hit || tm_hit)) err_q <= 1'b1;
        end
        RD: begin
          rdata_q <= ram_hit ? {2'b00, ram_q} : io_hit ? {2'b01, io_in} : tm_hit ? {2'b01, cnt_q} : 18'h2FFFF;
          state_q <= RESP;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign io_out    = io_out_q;
  assign err       = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table vectors, hand-written corner sequences and randomized traffic against a behavioural model
module tb_mem_responder;
  localparam logic [15:0] IOB = 16'hFF00;
  localparam int          RW  = 1024;
  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic [15:0] io_in;
  logic [15:0] io_out;
  logic        err;
  int          checks   = 0;
  int          failures = 0;
  mem_responder_if bus();
  mem_responder #(.RAM_WORDS(RW), .IO_BASE(IOB)) dut (
    .CLK(CLK), .CLR(CLR), .bus(bus), .io_in(io_in), .io_out(io_out), .err(err)
  );
  always #5 CLK = ~CLK;
  // behavioural model state
  logic [15:0] ram_m [int];
  logic [15:0] io_out_m;
  logic        err_m;
  logic [17:0] rdata_m;
  logic [17:0] mask_m;
  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] io;
    logic [17:0] rd;
    logic        e;
    logic [15:0] o;
    int          lat;
  } vec_t;
  vec_t tbl[14];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    io_out_m = '0;
    err_m    = 1'b0;
    rdata_m  = '0;
    mask_m   = 18'h3FFFF;
  endtask
  // decode rules: RAM below RW, switches/LEDs at IOB, counter at IOB+1 (if present), else unmapped
  task automatic model(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [15:0] io);
    if (int'(a) < RW) begin
      if (w) ram_m[int'(a)] = d;
      else if (ram_m.exists(int'(a))) begin rdata_m = {2'b00, ram_m[int'(a)]}; mask_m = 18'h3FFFF; end
      else begin rdata_m = 18'h0; mask_m = 18'h30000; end
    end else if (a == IOB) begin
      if (w) io_out_m = d;
      else begin rdata_m = {2'b01, io}; mask_m = 18'h3FFFF; end
`ifdef MMIO_TIMER_EN
    end else if (a == IOB + 16'd1) begin
      if (!w) begin rdata_m = 18'h10000; mask_m = 18'h30000; end
`endif
    end else begin
      err_m = 1'b1;
      if (!w) begin rdata_m = 18'h2FFFF; mask_m = 18'h3FFFF; end
    end
  endtask
  // one handshake: latency counted in edges from the accept edge; bounded wait
  task automatic txn(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [15:0] io,
                     output logic [17:0] rd, output int lat);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d; io_in = io;
    lat = 0;
    do begin
      @(posedge CLK); #1;
      lat++;
    end while (!bus.ready && lat < 10);
    rd = bus.rdata;
    bus.req = 1'b0;
  endtask
  task automatic do_check(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [15:0] io,
                          input string tag);
    logic [17:0] rd;
    int          lat;
    model(w, a, d, io);
    txn(w, a, d, io, rd, lat);
    chk({tag, "_rdata"}, rd & mask_m, rdata_m & mask_m);
    chk({tag, "_err"}, err, err_m);
    chk({tag, "_io_out"}, io_out, io_out_m);
    chk({tag, "_latency"}, lat, w ? 1 : 2);
    @(posedge CLK); #1;
    chk({tag, "_ready_drop"}, bus.ready, 1'b0);
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, bus.ready, 1'b0);
    chk({tag, "_rdata"}, bus.rdata, 18'h0);
    chk({tag, "_io_out"}, io_out, 16'h0);
    chk({tag, "_err"}, err, 1'b0);
  endtask
  task automatic pulse_reset();
    CLR = 1'b0;
    #2;
    check_reset_outputs("reset");
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK) CLR = 1'b1;
    @(posedge CLK); #1;
  endtask
  initial begin
    logic [17:0] rd;
    logic [17:0] rd2;
    logic [15:0] diff;
    int          lat;
    int          pulses;
    logic [15:0] a;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; io_in = '0;
    tbl[0]  = '{1'b1, 16'h0005, 16'hBEEF, 16'h0000, 18'h00000, 1'b0, 16'h0000, 1};
    tbl[1]  = '{1'b0, 16'h0005, 16'h0000, 16'h0000, 18'h0BEEF, 1'b0, 16'h0000, 2};
    tbl[2]  = '{1'b1, 16'hFF00, 16'h00A5, 16'h0000, 18'h0BEEF, 1'b0, 16'h00A5, 1};
    tbl[3]  = '{1'b0, 16'hFF00, 16'h0000, 16'h1234, 18'h11234, 1'b0, 16'h00A5, 2};
    tbl[4]  = '{1'b1, 16'h03FF, 16'h1111, 16'h0000, 18'h11234, 1'b0, 16'h00A5, 1};
    tbl[5]  = '{1'b0, 16'h03FF, 16'h0000, 16'h0000, 18'h01111, 1'b0, 16'h00A5, 2};
    tbl[6]  = '{1'b1, 16'h0000, 16'h2222, 16'h0000, 18'h01111, 1'b0, 16'h00A5, 1};
    tbl[7]  = '{1'b0, 16'h8000, 16'h0000, 16'h0000, 18'h2FFFF, 1'b1, 16'h00A5, 2};
    tbl[8]  = '{1'b0, 16'h0005, 16'h0000, 16'h0000, 18'h0BEEF, 1'b1, 16'h00A5, 2};
    tbl[9]  = '{1'b1, 16'h0400, 16'h3333, 16'h0000, 18'h0BEEF, 1'b1, 16'h00A5, 1};
    tbl[10] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 18'h02222, 1'b1, 16'h00A5, 2};
    tbl[11] = '{1'b1, 16'hFF00, 16'h5A5A, 16'hFFFF, 18'h02222, 1'b1, 16'h5A5A, 1};
    tbl[12] = '{1'b0, 16'hFF00, 16'h0000, 16'h0000, 18'h10000, 1'b1, 16'h5A5A, 2};
    tbl[13] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 18'h2FFFF, 1'b1, 16'h5A5A, 2};
    // power-on reset
    #3 CLR = 1'b0;
    #1 check_reset_outputs("por");
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK) CLR = 1'b1;
    @(posedge CLK); #1;
    // directed table
    for (int i = 0; i < 14; i++) begin
      model(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].io);
      txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].io, rd, lat);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].e);
      chk($sformatf("tbl%0d_io_out", i), io_out, tbl[i].o);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      @(posedge CLK); #1;
      chk($sformatf("tbl%0d_ready_drop", i), bus.ready, 1'b0);
    end
    // reset while a read sits in RD: no ready, everything cleared, RAM kept
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0005; io_in = 16'h0;
    @(posedge CLK); #1;
    CLR = 1'b0;
    bus.req = 1'b0;
    #2;
    check_reset_outputs("abort");
    model_reset();
    pulses = 0;
    repeat (2) begin
      @(posedge CLK); #1;
      if (bus.ready) pulses++;
    end
    @(negedge CLK) CLR = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      if (bus.ready) pulses++;
    end
    chk("abort_ready_pulses", pulses, 0);
    check_reset_outputs("abort_after");
    do_check(1'b0, 16'h0005, 16'h0, 16'h0, "ram_kept");
    // counter window at IOB+1
`ifdef MMIO_TIMER_EN
    txn(1'b0, IOB + 16'd1, 16'h0, 16'h0, rd, lat);
    repeat (8) @(posedge CLK);
    #1;
    txn(1'b0, IOB + 16'd1, 16'h0, 16'h0, rd2, lat);
    model(1'b0, IOB + 16'd1, 16'h0, 16'h0);
    diff = rd2[15:0] - rd[15:0];
    chk("timer_diff", diff, 16'd10);
    chk("timer_tag", rd2[17:16], 2'b01);
    chk("timer_err", err, 1'b0);
    @(posedge CLK); #1;
    do_check(1'b1, IOB + 16'd1, 16'h7777, 16'h0, "timer_wr");
`else
    do_check(1'b0, IOB + 16'd1, 16'h0, 16'h0, "notimer_rd");
`endif
    // unmapped write sets err; no aliasing of 0x0400 onto RAM word 0
    pulse_reset();
    do_check(1'b1, 16'h0400, 16'h3333, 16'h0, "unmapped_wr");
    do_check(1'b0, 16'h0000, 16'h0, 16'h0, "no_alias");
    // req held through ready starts a second read; addr changes in RD are ignored
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0005; io_in = 16'h0;
    @(posedge CLK); #1;
    chk("hold_k1_ready", bus.ready, 1'b0);
    bus.addr = 16'h03FF;
    @(posedge CLK); #1;
    chk("hold_k2_ready", bus.ready, 1'b1);
    chk("hold_k2_rdata", bus.rdata, 18'h0BEEF);
    @(posedge CLK); #1;
    chk("hold_k3_ready", bus.ready, 1'b0);
    @(posedge CLK); #1;
    chk("hold_k4_ready", bus.ready, 1'b0);
    bus.addr = 16'h0005;
    @(posedge CLK); #1;
    chk("hold_k5_ready", bus.ready, 1'b1);
    chk("hold_k5_rdata", bus.rdata, 18'h01111);
    bus.req = 1'b0;
    @(posedge CLK); #1;
    chk("hold_k6_ready", bus.ready, 1'b0);
    model(1'b0, 16'h03FF, 16'h0, 16'h0);
    // randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0, 1: a = 16'($urandom_range(0, 7));
        2:    a = 16'(RW - 8 + int'($urandom_range(0, 7)));
        3:    a = IOB;
        4:    a = IOB + 16'd1;
        default: a = 16'($urandom_range(16'h0400, 16'hFEFF));
      endcase
      do_check(1'($urandom_range(0, 1)), a, 16'($urandom), 16'($urandom), $sformatf("rnd%0d", i));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
